fetch_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the byte-addressed, little-endian, combinational instruction memory.
- Holds the PC and drives the memory address.
- Captures each returned 32-bit word with its PC in a small queue and hands entries to decode over a valid/ready handshake.
- Handles branch redirect, external stall, ECALL halt, and a saturating fetch counter.

---
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC + fetch queue front end with redirect, stall, ECALL halt; define FETCH_TRACE_EN for fetch trace output.
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int RESET_PC = 0,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [31:0]       dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc, hold_pc;
  logic [31:0] hold_instr;
  logic [31:0] q_instr [DEPTH];
  logic [ADDR_W-1:0] q_pc [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop, is_ecall;
  assign imem_addr = pc;
  assign dec_valid = count != '0;
  assign dec_instr = dec_valid ? q_instr[rd_ptr] : hold_instr;
  assign dec_pc = dec_valid ? q_pc[rd_ptr] : hold_pc;
  assign halted = state == HALT;
  always_comb begin
    is_ecall = imem_instr == 32'h0000_0073;
    push = state == RUN && !stall && !redirect_valid && count < CW'(DEPTH);
    pop = dec_valid && dec_ready && !redirect_valid;
    state_nx = redirect_valid ? RUN : (push && is_ecall) ? HALT : state;
  end
  always_ff @(posedge clk)
    if (rst) state <= RUN;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (push) begin
      q_instr[wr_ptr] <= imem_instr;
      q_pc[wr_ptr] <= pc;
    end
  // hold registers track the visible head so outputs freeze once the queue empties
  always_ff @(posedge clk)
    if (rst) begin
      pc <= ADDR_W'(RESET_PC);
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      fetch_count <= '0;
      hold_instr <= '0;
      hold_pc <= '0;
    end else begin
      if (dec_valid) begin
        hold_instr <= dec_instr;
        hold_pc <= dec_pc;
      end
      if (redirect_valid) begin
        pc <= redirect_pc & ~ADDR_W'(3);
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          pc <= pc + ADDR_W'(4);
          if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk)
    if (!rst) begin
      if (push) $display("fetch: pc=%h instr=%h op=%b", pc, imem_instr, imem_instr[6:0]);
      if (redirect_valid) $display("fetch: redirect -> %h", redirect_pc & ~ADDR_W'(3));
      if (push && is_ecall) $display("fetch: halted at %h", pc);
    end
`else
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against hand-computed values.
module tb_fetch_unit;
  logic clk = 0, rst = 0, stall = 0, redirect_valid = 0, dec_ready = 0, ecall_en = 0;
  logic [7:0] imem_addr, redirect_pc = 0, dec_pc;
  logic [31:0] imem_instr, dec_instr;
  logic dec_valid, halted;
  logic [15:0] fetch_count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign imem_instr = (ecall_en && imem_addr == 8'h0C) ? 32'h0000_0073 : {24'h0, imem_addr};
  fetch_unit #(.ADDR_W(8), .RESET_PC(0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc), .halted(halted),
    .fetch_count(fetch_count)
  );
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset;
    rst = 1;
    tick();
    rst = 0;
  endtask
  task automatic test_reset;
    dec_ready = 0;
    do_reset();
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dec_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", imem_addr); end
    checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    checks++; if ({dec_pc, dec_instr} !== 40'h0) begin errors++; $display("FAIL reset_dec got %h/%h want 0/0", dec_pc, dec_instr); end
  endtask
  task automatic test_stream;
    dec_ready = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'(4 * (k - 1)) || dec_instr !== 32'(4 * (k - 1)))
        begin errors++; $display("FAIL stream_%0d got v=%b pc=%h instr=%h want v=1 pc=%h", k, dec_valid, dec_pc, dec_instr, 8'(4 * (k - 1))); end
    end
    checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL stream_count got %0d want 3", fetch_count); end
  endtask
  task automatic test_backpressure;
    dec_ready = 0;
    do_reset();
    tick(3);
    checks++; if (dec_valid !== 1'b1 || imem_addr !== 8'h08 || fetch_count !== 16'd2)
      begin errors++; $display("FAIL bp_full got v=%b addr=%h cnt=%0d want 1/08/2", dec_valid, imem_addr, fetch_count); end
    dec_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'(4 * i))
        begin errors++; $display("FAIL bp_drain_%0d got v=%b pc=%h want 1/%h", i, dec_valid, dec_pc, 8'(4 * i)); end
      tick();
    end
  endtask
  task automatic test_redirect_flush;
    dec_ready = 0;
    do_reset();
    tick(2);
    redirect_valid = 1; redirect_pc = 8'h43;
    tick();
    redirect_valid = 0;
    checks++; if (dec_valid !== 1'b0 || imem_addr !== 8'h40)
      begin errors++; $display("FAIL redir_flush got v=%b addr=%h want 0/40", dec_valid, imem_addr); end
    tick();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'h40 || dec_instr !== 32'h40)
      begin errors++; $display("FAIL redir_target got v=%b pc=%h instr=%h want 1/40/40", dec_valid, dec_pc, dec_instr); end
  endtask
  task automatic test_wrap;
    logic [7:0] exp [4];
    exp = '{8'hF8, 8'hFC, 8'h00, 8'h04};
    dec_ready = 1;
    redirect_valid = 1; redirect_pc = 8'hF8;
    tick();
    redirect_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (dec_valid !== 1'b1 || dec_pc !== exp[i])
        begin errors++; $display("FAIL wrap_%0d got v=%b pc=%h want 1/%h", i, dec_valid, dec_pc, exp[i]); end
    end
  endtask
  task automatic test_ecall;
    ecall_en = 1;
    dec_ready = 1;
    do_reset();
    tick(3);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL ecall_early_halt got %b want 0", halted); end
    tick();
    checks++; if (dec_pc !== 8'h0C || dec_instr !== 32'h73 || halted !== 1'b1 || imem_addr !== 8'h10)
      begin errors++; $display("FAIL ecall_push got pc=%h instr=%h h=%b addr=%h want 0c/73/1/10", dec_pc, dec_instr, halted, imem_addr); end
    tick(10);
    checks++; if (imem_addr !== 8'h10 || fetch_count !== 16'd4 || halted !== 1'b1 || dec_valid !== 1'b0)
      begin errors++; $display("FAIL ecall_frozen got addr=%h cnt=%0d h=%b v=%b want 10/4/1/0", imem_addr, fetch_count, halted, dec_valid); end
    redirect_valid = 1; redirect_pc = 8'h20;
    tick();
    redirect_valid = 0;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL ecall_resume got %b want 0", halted); end
    tick();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'h20)
      begin errors++; $display("FAIL ecall_target got v=%b pc=%h want 1/20", dec_valid, dec_pc); end
    ecall_en = 0;
  endtask
  task automatic test_stall;
    dec_ready = 1;
    do_reset();
    stall = 1;
    tick(3);
    checks++; if (dec_valid !== 1'b0 || imem_addr !== 8'h00 || fetch_count !== 16'd0)
      begin errors++; $display("FAIL stall_hold got v=%b addr=%h cnt=%0d want 0/00/0", dec_valid, imem_addr, fetch_count); end
    stall = 0;
    tick();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'h00 || fetch_count !== 16'd1)
      begin errors++; $display("FAIL stall_release got v=%b pc=%h cnt=%0d want 1/00/1", dec_valid, dec_pc, fetch_count); end
  endtask
  task automatic test_reset_midway;
    dec_ready = 0;
    do_reset();
    tick(2);
    stall = 1;
    do_reset();
    checks++; if (dec_valid !== 1'b0 || imem_addr !== 8'h00 || fetch_count !== 16'd0 || halted !== 1'b0)
      begin errors++; $display("FAIL midreset got v=%b addr=%h cnt=%0d h=%b want 0/00/0/0", dec_valid, imem_addr, fetch_count, halted); end
    stall = 0;
  endtask
  initial begin
    tick();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_wrap();
    test_ecall();
    test_stall();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
